// File: rtl/dff_ram_ctrl_if.sv
// Command/response bus between a requester and dff_ram_ctrl.
// The master issues commands and consumes responses; the slave is the controller.
interface dff_ram_ctrl_if #(
    parameter int AW = 2,
    parameter int DW = 72
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dff_ram_ctrl.sv
// Single-outstanding request controller for the 4x72 flop RAM (active-low strobes).
// Optional per-byte even parity in bits [71:64] when DFF_RAM_CTRL_PARITY_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a command; strobes inactive
// ISSUE   | RAM strobe active for this one cycle
// CAPTURE | read data valid on ram_rdata; loaded into the response register
// RESP    | response held until the consumer takes it
module dff_ram_ctrl #(
    parameter int AW = 2,
    parameter int DW = 72
) (
    input  logic          clk,
    input  logic          rst_n,
    dff_ram_ctrl_if.slave bus,
    output logic          ram_en_n,
    output logic          ram_wr_n,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          en_n_nxt;
    logic          wr_n_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wdata_nxt;
    logic          rsp_valid_q, rsp_valid_nxt;
    logic [DW-1:0] rsp_data_q, rsp_data_nxt;
    logic          rsp_err_q, rsp_err_nxt;
    logic [DW-1:0] wdata_fmt;
    logic          rd_err;

    // Write word as stored: parity byte replaces the top byte when enabled.
    always_comb begin
        wdata_fmt = bus.cmd_wdata;
`ifdef DFF_RAM_CTRL_PARITY_EN
        for (int i = 0; i < 8; i++) begin
            wdata_fmt[64+i] = ^bus.cmd_wdata[8*i +: 8];
        end
`endif
    end

    always_comb begin
        rd_err = 1'b0;
`ifdef DFF_RAM_CTRL_PARITY_EN
        for (int i = 0; i < 8; i++) begin
            if (ram_rdata[64+i] != (^ram_rdata[8*i +: 8])) begin
                rd_err = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_nxt     = state;
        en_n_nxt      = 1'b1;
        wr_n_nxt      = 1'b1;
        addr_nxt      = ram_addr;
        wdata_nxt     = ram_wdata;
        rsp_valid_nxt = rsp_valid_q;
        rsp_data_nxt  = rsp_data_q;
        rsp_err_nxt   = rsp_err_q;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_nxt  = bus.cmd_addr;
                    wdata_nxt = wdata_fmt;
                    en_n_nxt  = 1'b0;
                    wr_n_nxt  = !bus.cmd_we;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // ram_wr_n is still the strobe of the command being issued.
                state_nxt = ram_wr_n ? CAPTURE : IDLE;
            end
            CAPTURE: begin
                rsp_data_nxt  = ram_rdata;
                rsp_err_nxt   = rd_err;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ram_en_n    <= 1'b1;
            ram_wr_n    <= 1'b1;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ram_en_n    <= en_n_nxt;
            ram_wr_n    <= wr_n_nxt;
            ram_addr    <= addr_nxt;
            ram_wdata   <= wdata_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_data_q  <= rsp_data_nxt;
            rsp_err_q   <= rsp_err_nxt;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dff_ram_ctrl.sv
// Bench for dff_ram_ctrl with a behavioural 4x72 RAM and an array/queue reference model.
// Parity expectations follow DFF_RAM_CTRL_PARITY_EN at compile time.
module tb_dff_ram_ctrl;
    localparam int AW = 2;
    localparam int DW = 72;
`ifdef DFF_RAM_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dff_ram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    logic          ram_en_n;
    logic          ram_wr_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    dff_ram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_en_n  (ram_en_n),
        .ram_wr_n  (ram_wr_n),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Behavioural RAM: acts on the edge that ends the strobe cycle; no reset.
    logic [DW-1:0] ram_mem [4];
    logic          bd_req  = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    always @(posedge clk) begin
        if (bd_req) begin
            ram_mem[bd_addr][0] <= ~ram_mem[bd_addr][0];
        end else if (!ram_en_n) begin
            if (!ram_wr_n) ram_mem[ram_addr] <= ram_wdata;
            else           ram_rdata         <= ram_mem[ram_addr];
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    logic [DW-1:0] mem_model [4];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rsp_data = '0;
    logic          last_rsp_err  = 1'b0;

    function automatic logic [DW-1:0] exp_store(input logic [DW-1:0] d);
        logic [DW-1:0] s = d;
        for (int i = 0; i < 8; i++) begin
            if (PAR) s[64+i] = ^d[8*i +: 8];
        end
        return s;
    endfunction

    function automatic logic exp_err(input logic [DW-1:0] w);
        logic e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((^w[8*i +: 8]) != w[64+i]) e = 1'b1;
        end
        return PAR && e;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle plus the per-cycle protocol/model comparison.
    task automatic step();
        logic          en_b;
        logic          v_b;
        logic          r_b;
        logic          e_b;
        logic [DW-1:0] d_b;
        logic [DW-1:0] e;
        en_b = ram_en_n;
        v_b  = bus.rsp_valid;
        r_b  = bus.rsp_ready;
        d_b  = bus.rsp_data;
        e_b  = bus.rsp_err;
        @(posedge clk);
        #1;
        cyc++;
        if (!ram_en_n) chkb("strobe_one_cycle", en_b, 1'b1);
        if (bus.rsp_valid && !v_b) begin
            chki("rsp_latency", cyc - last_acc, 2);
            last_rsp_data = bus.rsp_data;
            last_rsp_err  = bus.rsp_err;
            if (exp_q.size() == 0) begin
                chkb("rsp_unexpected", bus.rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", bus.rsp_data, e);
                chkb("rsp_err", bus.rsp_err, exp_err(e));
            end
        end
        if (v_b && !r_b) begin
            chkb("rsp_hold_valid", bus.rsp_valid, 1'b1);
            chk("rsp_hold_data", bus.rsp_data, d_b);
            chkb("rsp_hold_err", bus.rsp_err, e_b);
        end
        if (v_b && r_b) begin
            chkb("rsp_release", bus.rsp_valid, 1'b0);
            chkb("ready_after_rsp", bus.cmd_ready, 1'b1);
        end
        if (bus.rsp_valid) begin
            chkb("busy_cmd_ready", bus.cmd_ready, 1'b0);
            chkb("busy_no_strobe", ram_en_n, 1'b1);
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 8 && !bus.cmd_ready; i++) step();
        chkb("cmd_ready_wait", bus.cmd_ready, 1'b1);
        step();
        last_acc = cyc;
        bus.cmd_valid = 1'b0;
        chkb("accept_ready_low", bus.cmd_ready, 1'b0);
        chkb("accept_en", ram_en_n, 1'b0);
        chkb("accept_wr", ram_wr_n, !we);
        chki("accept_addr", int'(ram_addr), int'(a));
        if (we) begin
            chk("accept_wdata", ram_wdata, exp_store(d));
            mem_model[a] = exp_store(d);
        end else begin
            exp_q.push_back(mem_model[a]);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold, input bit poke);
        bus.rsp_ready = (hold == 0);
        issue(1'b0, a, '0);
        for (int i = 0; i < 8 && !bus.rsp_valid; i++) step();
        chkb("rsp_timeout", bus.rsp_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = poke && (i == 1 || i == 2);
            bus.cmd_we    = 1'b1;
            bus.cmd_addr  = a;
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int a0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem_model[i] = '0;

        #12;
        chkb("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chkb("rst_en_n", ram_en_n, 1'b1);
        chkb("rst_wr_n", ram_wr_n, 1'b1);
        chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, '0);
        chkb("rst_rsp_err", bus.rsp_err, 1'b0);
        chki("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", ram_wdata, '0);
        rst_n = 1'b1;
        step();

        // Initialise every entry so later reads are defined.
        for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), {8'h00, 32'h0, 32'(i * 32'h01010101)});

        issue(1'b1, 2'd2, 72'h00_1122334455667788);
        a0 = last_acc;
        do_read(2'd2, 0, 1'b0);
        chk("lit_rd2", {8'h00, last_rsp_data[63:0]}, 72'h00_1122334455667788);
        chki("read_after_write_gap", last_acc - a0, 2);

        a0 = last_acc;
        do_read(2'd3, 0, 1'b0);
        chki("read_rate", last_acc - a0, 4);

        issue(1'b1, 2'd1, 72'hAA_AAAA_AAAA_AAAA_AAAA);
        do_read(2'd1, 0, 1'b0);
        chk("lit_b2b", last_rsp_data, PAR ? 72'h00_AAAA_AAAA_AAAA_AAAA : 72'hAA_AAAA_AAAA_AAAA_AAAA);

        issue(1'b1, 2'd0, 72'h5A_0123456789ABCDEF);
        a0 = last_acc;
        issue(1'b1, 2'd3, 72'hC3_FEDCBA9876543210);
        chki("write_rate", last_acc - a0, 2);
        do_read(2'd3, 0, 1'b0);
        do_read(2'd0, 0, 1'b0);

        do_read(2'd2, 5, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            chkb("idle_no_strobe", ram_en_n, 1'b1);
        end

        // Reset during ISSUE (k=0) and during CAPTURE (k=1).
        for (int k = 0; k < 2; k++) begin
            bus.rsp_ready = 1'b1;
            issue(1'b0, 2'd1, '0);
            for (int j = 0; j < k; j++) step();
            rst_n = 1'b0;
            #1;
            chkb("mid_rst_en_n", ram_en_n, 1'b1);
            chkb("mid_rst_wr_n", ram_wr_n, 1'b1);
            chkb("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
            chkb("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
            chk("mid_rst_rsp_data", bus.rsp_data, '0);
            exp_q.delete();
            step();
            step();
            rst_n = 1'b1;
            step();
            chkb("post_rst_no_rsp", bus.rsp_valid, 1'b0);
        end
        bus.rsp_ready = 1'b0;
        do_read(2'd1, 0, 1'b0);
        chk("post_rst_contents", last_rsp_data, PAR ? 72'h00_AAAA_AAAA_AAAA_AAAA : 72'hAA_AAAA_AAAA_AAAA_AAAA);

        issue(1'b1, 2'd0, 72'hFF_0000000000000001);
        do_read(2'd0, 0, 1'b0);
        chk("lit_par_top", {64'h0, last_rsp_data[71:64]}, PAR ? 72'h01 : 72'hFF);
        chkb("lit_par_err_clean", last_rsp_err, 1'b0);

        bd_addr = 2'd0;
        bd_req  = 1'b1;
        step();
        bd_req  = 1'b0;
        mem_model[0][0] = ~mem_model[0][0];
        do_read(2'd0, 0, 1'b0);
        chkb("lit_par_err_flip", last_rsp_err, PAR);
        chkb("lit_flip_bit0", last_rsp_data[0], 1'b0);
        chki("rsp_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
